// File: rtl/char_lane_render_if.sv
// Purpose : move-request / pixel-write bundle between the game FSM, char_lane_render and the VGA adapter.
// Latency : n/a (signal bundle only).
// Backpressure: none; the pixel stream is fire-and-forget, and the producer paces moves using Busy.
// Ports   : MoveLeft/MoveRight (requests in), CurrPos (lane), XOut/YOut/Color/Plot (VGA write), Busy, DoneDrawing.
interface char_lane_render_if;
    logic       MoveLeft;
    logic       MoveRight;
    logic [1:0] CurrPos;
    logic [7:0] XOut;
    logic [6:0] YOut;
    logic [2:0] Color;
    logic       Plot;
    logic       Busy;
    logic       DoneDrawing;

    // master: the renderer, which drives the pixel stream and status.
    modport master (
        input  MoveLeft, MoveRight,
        output CurrPos, XOut, YOut, Color, Plot, Busy, DoneDrawing
    );

    // slave: the game FSM / VGA side, which issues moves and consumes pixels.
    modport slave (
        output MoveLeft, MoveRight,
        input  CurrPos, XOut, YOut, Color, Plot, Busy, DoneDrawing
    );
endinterface

// File: rtl/char_lane_render.sv
// Purpose : holds the player lane (0..3); on each move, erases the 9x5 sprite at the old lane, then draws it at the new lane.
// Latency : first pixel 1 cycle after acceptance; 45 erase + 45 draw pixels back to back; DoneDrawing on the next cycle.
// Backpressure: none downstream. Requests arriving while busy go into a one-deep slot; later ones are dropped.
// Ports   : Clock, Reset (sync, active-low), bus (char_lane_render_if.master).
// Option  : define CHAR_OUTLINE_EN to draw only the sprite border in CHAR_COLOR; the interior uses BG_COLOR.
module char_lane_render #(
    parameter int         CHAR_W     = 9,
    parameter int         CHAR_H     = 5,
    parameter int         Y_BASE     = 102,
    parameter logic [2:0] CHAR_COLOR = 3'b110,
    parameter logic [2:0] BG_COLOR   = 3'b000
) (
    input  logic               Clock,
    input  logic               Reset,
    char_lane_render_if.master bus
);
    localparam int XW = $clog2(CHAR_W);
    localparam int YW = $clog2(CHAR_H);

    typedef enum logic [2:0] {INIT, IDLE, ERASE, DRAW, DONE} state_t;

    state_t        state, nxt_state;
    logic [XW-1:0] xcnt, nxt_xcnt;
    logic [YW-1:0] ycnt, nxt_ycnt;
    logic [1:0]    pos, nxt_pos;          // committed lane
    logic [1:0]    tgt, nxt_tgt;          // lane being moved to
    logic          pend_vld, nxt_pend_vld;
    logic          pend_dir, nxt_pend_dir; // 1 = right

    logic [7:0]    x_q, nxt_x;
    logic [6:0]    y_q, nxt_y;
    logic [2:0]    col_q, nxt_col;
    logic          plot_q, nxt_plot;
    logic          busy_q, nxt_busy;
    logic          done_q, nxt_done;

    logic          live_vld, live_dir;
    logic          req_vld, req_dir, req_ok;
    logic          last_x, last_y;
    logic [2:0]    draw_col;

    function automatic logic [7:0] lane_base(input logic [1:0] lane);
        case (lane)
            2'd0:    lane_base = 8'd6;
            2'd1:    lane_base = 8'd24;
            2'd2:    lane_base = 8'd78;
            default: lane_base = 8'd132;
        endcase
    endfunction

    // Both directions at once cancel out and never count as a request.
    assign live_vld = bus.MoveLeft ^ bus.MoveRight;
    assign live_dir = bus.MoveRight;
    assign last_x   = (xcnt == XW'(CHAR_W - 1));
    assign last_y   = (ycnt == YW'(CHAR_H - 1));

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= INIT;
            xcnt     <= '0;
            ycnt     <= '0;
            pos      <= 2'd0;
            tgt      <= 2'd0;
            pend_vld <= 1'b0;
            pend_dir <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            col_q    <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= nxt_state;
            xcnt     <= nxt_xcnt;
            ycnt     <= nxt_ycnt;
            pos      <= nxt_pos;
            tgt      <= nxt_tgt;
            pend_vld <= nxt_pend_vld;
            pend_dir <= nxt_pend_dir;
            x_q      <= nxt_x;
            y_q      <= nxt_y;
            col_q    <= nxt_col;
            plot_q   <= nxt_plot;
            busy_q   <= nxt_busy;
            done_q   <= nxt_done;
        end
    end

    // Next state, counters and the registered pixel word. Outputs are computed from the
    // next-cycle state, so the registered pixel always matches the state it belongs to.
    always_comb begin
        nxt_state    = state;
        nxt_xcnt     = xcnt;
        nxt_ycnt     = ycnt;
        nxt_pos      = pos;
        nxt_tgt      = tgt;
        nxt_pend_vld = pend_vld;
        nxt_pend_dir = pend_dir;
        req_vld      = 1'b0;
        req_dir      = 1'b0;
        req_ok       = 1'b0;

        case (state)
            INIT: begin
                nxt_state = DRAW;
                nxt_xcnt  = '0;
                nxt_ycnt  = '0;
            end
            IDLE: begin
                // A pending move takes priority. A live request in the same cycle is dropped.
                if (pend_vld) begin
                    req_vld      = 1'b1;
                    req_dir      = pend_dir;
                    nxt_pend_vld = 1'b0;
                end else if (live_vld) begin
                    req_vld = 1'b1;
                    req_dir = live_dir;
                end
                req_ok = req_vld && (req_dir ? (pos != 2'd3) : (pos != 2'd0));
                if (req_ok) begin
                    nxt_state = ERASE;
                    nxt_tgt   = req_dir ? pos + 2'd1 : pos - 2'd1;
                    nxt_xcnt  = '0;
                    nxt_ycnt  = '0;
                end
            end
            ERASE, DRAW: begin
                if (last_x) begin
                    nxt_xcnt = '0;
                    nxt_ycnt = last_y ? '0 : ycnt + YW'(1);
                end else begin
                    nxt_xcnt = xcnt + XW'(1);
                end
                if (last_x && last_y) begin
                    if (state == ERASE) begin
                        nxt_state = DRAW;
                        nxt_pos   = tgt;   // lane commits on the first draw pixel
                    end else begin
                        nxt_state = DONE;
                    end
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = INIT;
        endcase

        // Outside IDLE, the first request that arrives is parked in the one-deep slot.
        if (state != IDLE && live_vld && !pend_vld) begin
            nxt_pend_vld = 1'b1;
            nxt_pend_dir = live_dir;
        end

`ifdef CHAR_OUTLINE_EN
        draw_col = (nxt_xcnt == '0 || nxt_xcnt == XW'(CHAR_W - 1) ||
                    nxt_ycnt == '0 || nxt_ycnt == YW'(CHAR_H - 1)) ? CHAR_COLOR : BG_COLOR;
`else
        draw_col = CHAR_COLOR;
`endif

        nxt_plot = (nxt_state == ERASE) || (nxt_state == DRAW);
        nxt_done = (nxt_state == DONE);
        nxt_busy = (nxt_state != IDLE) || nxt_pend_vld;
        nxt_x    = '0;
        nxt_y    = '0;
        nxt_col  = '0;
        if (nxt_plot) begin
            // ERASE runs before pos updates; DRAW runs after. Either way, nxt_pos is the lane to address.
            nxt_x   = lane_base(nxt_pos) + 8'(nxt_xcnt);
            nxt_y   = 7'(Y_BASE) + 7'(nxt_ycnt);
            nxt_col = (nxt_state == ERASE) ? BG_COLOR : draw_col;
        end
    end

    assign bus.CurrPos     = pos;
    assign bus.XOut        = x_q;
    assign bus.YOut        = y_q;
    assign bus.Color       = col_q;
    assign bus.Plot        = plot_q;
    assign bus.Busy        = busy_q;
    assign bus.DoneDrawing = done_q;
endmodule

// File: tb/tb_char_lane_render.sv
// Testbench for char_lane_render: pixels and DoneDrawing pulses are predicted
// into queues as stimulus is driven, then popped as the DUT produces them, with exact cycle stamps.
module tb_char_lane_render;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    char_lane_render_if bus();

    char_lane_render dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int x;
        int y;
        int col;
        int pos;
    } pix_t;

    pix_t pix_q[$];
    int   done_cyc_q[$];
    pix_t mon_r;
    int   mon_d;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int lane_x(input int lane);
        case (lane)
            0:       return 6;
            1:       return 24;
            2:       return 78;
            default: return 132;
        endcase
    endfunction

    function automatic int draw_col(input int x, input int y);
`ifdef CHAR_OUTLINE_EN
        return (x == 0 || x == 8 || y == 0 || y == 4) ? 6 : 0;
`else
        return 6;
`endif
    endfunction

    // Queue n_pix pixels of a pass; pixel k (0-based) is expected on cycle start+1+k.
    task automatic push_pass(input int start, input int lane, input bit erase,
                             input int pos_exp, input int n_pix);
        pix_t p;
        for (int k = 0; k < n_pix; k++) begin
            p.cyc = start + 1 + k;
            p.x   = lane_x(lane) + (k % 9);
            p.y   = 102 + (k / 9);
            p.col = erase ? 0 : draw_col(k % 9, k / 9);
            p.pos = pos_exp;
            pix_q.push_back(p);
        end
    endtask

    // Full move: erase the old lane, then draw the new lane, then DONE.
    task automatic push_move(input int start, input int from, input int to);
        push_pass(start, from, 1'b1, from, 45);
        push_pass(start + 45, to, 1'b0, to, 45);
        done_cyc_q.push_back(start + 91);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Drive a one-cycle request so that it is sampled at the edge ending cycle c.
    task automatic pulse_at(input int c, input bit l, input bit r);
        wait_cyc(c);
        bus.MoveLeft  = l;
        bus.MoveRight = r;
        @(posedge Clock);
        #1;
        bus.MoveLeft  = 1'b0;
        bus.MoveRight = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 600 && (pix_q.size() != 0 || done_cyc_q.size() != 0); i++)
            @(negedge Clock);
        chk(tag, pix_q.size() + done_cyc_q.size(), 0);
        repeat (20) @(negedge Clock);
        chk({tag, "_busy"}, int'(bus.Busy), 0);
    endtask

    // Request that must be ignored: no pixels, no DoneDrawing (the monitor flags any), Busy stays 0.
    task automatic ignored(input string tag, input bit l, input bit r, input int lane);
        pulse_at(cyc + 1, l, r);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            chk({tag, "_busy"}, int'(bus.Busy), 0);
        end
        chk({tag, "_pos"}, int'(bus.CurrPos), lane);
        drain(tag);
    endtask

    // Scoreboard monitor: sample away from the active edge.
    always @(negedge Clock) begin
        if (bus.Plot) begin
            if (pix_q.size() == 0) begin
                chk("unexpected_plot", 1, 0);
            end else begin
                mon_r = pix_q.pop_front();
                chk("pix_cycle", cyc, mon_r.cyc);
                chk("pix_x", int'(bus.XOut), mon_r.x);
                chk("pix_y", int'(bus.YOut), mon_r.y);
                chk("pix_color", int'(bus.Color), mon_r.col);
                chk("pix_pos", int'(bus.CurrPos), mon_r.pos);
            end
        end
        if (bus.DoneDrawing) begin
            if (done_cyc_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_d = done_cyc_q.pop_front();
                chk("done_cycle", cyc, mon_d);
                chk("done_plot", int'(bus.Plot), 0);
                chk("done_busy", int'(bus.Busy), 1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        bus.MoveLeft  = 1'b0;
        bus.MoveRight = 1'b0;
        Reset         = 1'b0;

        // Reset state
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_plot", int'(bus.Plot), 0);
        chk("rst_busy", int'(bus.Busy), 1);
        chk("rst_done", int'(bus.DoneDrawing), 0);
        chk("rst_x", int'(bus.XOut), 0);
        chk("rst_y", int'(bus.YOut), 0);
        chk("rst_color", int'(bus.Color), 0);
        chk("rst_pos", int'(bus.CurrPos), 0);

        // Initial draw at lane 0 after reset release
        r = cyc;
        push_pass(r, 0, 1'b0, 0, 45);
        done_cyc_q.push_back(r + 46);
        Reset = 1'b1;
        drain("init_draw");

        // Boundary: left at lane 0
        ignored("left_at_0", 1'b1, 1'b0, 0);

        // Lane 0 -> 1
        n = cyc + 1;
        push_move(n, 0, 1);
        pulse_at(n, 1'b0, 1'b1);
        drain("move_0_1");

        // Lane 1 -> 2, second right pending -> 3, left dropped (slot full)
        n = cyc + 1;
        push_move(n, 1, 2);
        push_move(n + 92, 2, 3);
        pulse_at(n, 1'b0, 1'b1);
        pulse_at(n + 10, 1'b0, 1'b1);
        pulse_at(n + 20, 1'b1, 1'b0);
        drain("pending_chain");
        chk("pending_chain_pos", int'(bus.CurrPos), 3);

        // Boundary: right at lane 3
        ignored("right_at_3", 1'b0, 1'b1, 3);

        // Lane 3 -> 2
        n = cyc + 1;
        push_move(n, 3, 2);
        pulse_at(n, 1'b1, 1'b0);
        drain("move_3_2");

        // Boundary: both directions together at lane 2
        ignored("both_at_2", 1'b1, 1'b1, 2);

        // Reset at erase pixel 30 from lane 2, with a pending request that must be cleared
        n = cyc + 1;
        push_pass(n, 2, 1'b1, 2, 30);
        pulse_at(n, 1'b1, 1'b0);
        pulse_at(n + 10, 1'b0, 1'b1);
        wait_cyc(n + 30);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("midrst_plot", int'(bus.Plot), 0);
        chk("midrst_busy", int'(bus.Busy), 1);
        chk("midrst_pos", int'(bus.CurrPos), 0);
        chk("midrst_pix_left", pix_q.size(), 0);
        @(posedge Clock);
        #1;
        r = cyc;
        push_pass(r, 0, 1'b0, 0, 45);
        done_cyc_q.push_back(r + 46);
        Reset = 1'b1;
        drain("midrst_redraw");
        repeat (150) @(negedge Clock);
        chk("midrst_final_pos", int'(bus.CurrPos), 0);
        chk("midrst_final_busy", int'(bus.Busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/char_lane_render.md
Name: char_lane_render

Overview:
- Sits between the game control FSM and the VGA adapter.
- Holds the player character's lane position (0..3) and accepts left/right move requests.
- For each accepted move, erases the 9x5 character at the old lane, then draws it at the new lane.
- Emits one pixel per cycle (X, Y, colour, plot strobe) straight into the VGA adapter's write port, and reports completion to the game FSM.

Parameters:
- CHAR_W, 9, character width in pixels
- CHAR_H, 5, character height in pixels
- Y_BASE, 102, top row of the character (all lanes)
- CHAR_COLOR, 3'b110, colour used in the draw pass
- BG_COLOR, 3'b000, colour used in the erase pass

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- MoveLeft  in  1  single-cycle request to move one lane left
- MoveRight  in  1  single-cycle request to move one lane right
- CurrPos  out  2  committed lane position, 0..3
- XOut  out  8  pixel X to the VGA adapter
- YOut  out  7  pixel Y to the VGA adapter
- Color  out  3  pixel colour to the VGA adapter
- Plot  out  1  VGA write enable; XOut/YOut/Color are valid when high
- Busy  out  1  a pass is in progress or pending
- DoneDrawing  out  1  one-cycle pulse when a draw pass completes

Behaviour:
- Lane X bases: lane 0 = 6, lane 1 = 24, lane 2 = 78, lane 3 = 132.
- Pixel address: XOut = base + xcnt, YOut = Y_BASE + ycnt.
- Scan order is row-major: xcnt 0..CHAR_W-1 runs fastest, then ycnt 0..CHAR_H-1. One pass = 45 pixels, one per cycle.
- All outputs are registered.
- Reset (Reset=0 at an edge), from any state:
  - FSM goes to INIT; CurrPos=0; pending slot cleared.
  - Outputs: XOut=0, YOut=0, Color=0, Plot=0, DoneDrawing=0, Busy=1.
- States: INIT, IDLE, ERASE, DRAW, DONE.
- INIT: lasts one cycle, then goes to DRAW at lane 0 with no erase pass. Its pixels appear on cycles 1..45 after reset release. DONE follows on cycle 46.
- IDLE: Busy=0 unless the pending slot is full; Plot=0.
  - A request is a pending move, or else a live MoveLeft/MoveRight.
  - It is valid if the target lane is in 0..3.
  - A valid request is accepted at the edge ending cycle 0 and the target lane is latched.
  - Pixels follow: ERASE at the old lane with BG_COLOR on cycles 1..45, then DRAW at the new lane with CHAR_COLOR on cycles 46..90. Plot is high on all 90 cycles with no gap.
  - CurrPos updates to the new lane on cycle 46, the first DRAW pixel.
- DONE: one cycle with Plot=0, DoneDrawing=1, Busy=1. The FSM then returns to IDLE.
- Boundary conditions:
  - MoveLeft at lane 0 or MoveRight at lane 3: ignored. No pass, no DoneDrawing.
  - MoveLeft and MoveRight asserted in the same cycle: ignored.
  - A request while not in IDLE: stored in a one-deep pending slot if the slot is empty; otherwise dropped (first request wins).
  - Pending requests are validated against the committed lane when taken from the slot; an invalid pending request is discarded.
  - A pending request is accepted on the first IDLE cycle after DONE. Its first pixel appears 2 cycles after DONE.
  - Reset mid-pass aborts immediately. Plot goes low on the next cycle, and the sequence restarts with INIT.
- Counters use wrap-free compare: xcnt resets to 0 when it reaches CHAR_W-1 while ycnt increments. The pass ends when xcnt=CHAR_W-1 and ycnt=CHAR_H-1.

Optional Feature:
- Macro: CHAR_OUTLINE_EN.
- Defined: in DRAW, border pixels (xcnt=0, xcnt=CHAR_W-1, ycnt=0 or ycnt=CHAR_H-1) use CHAR_COLOR and interior pixels use BG_COLOR. Plot stays high for all 45 pixels. ERASE is unchanged.
- Undefined: every DRAW pixel uses CHAR_COLOR.

Test Plan:
- Reset release -> Plot high on cycles 1..45 with X 6..14 and Y 102..106 in row-major order, Color=3'b110. DoneDrawing pulses on cycle 46. CurrPos=0.
- From lane 0, MoveRight pulse -> 45 pixels at X 6..14 with Color=0, immediately followed by 45 pixels at X 24..32 with Color=3'b110. CurrPos=1 from the first draw pixel. One DoneDrawing pulse.
- MoveLeft at lane 0; MoveLeft+MoveRight together at lane 2 -> no Plot, no DoneDrawing, CurrPos unchanged, Busy stays 0.
- From lane 1, MoveRight followed by MoveRight 10 cycles later and MoveLeft 20 cycles later -> two complete erase/draw sequences ending at lane 3; the MoveLeft is dropped. Two DoneDrawing pulses.
- Reset asserted at pixel 30 of an ERASE pass from lane 2 -> Plot low the next cycle, pending slot cleared, then a fresh 45-pixel draw at X 6..14 and CurrPos=0.
- With CHAR_OUTLINE_EN defined, initial draw -> pixel (X=10, Y=104) has Color=0 and pixel (X=6, Y=104) has Color=3'b110.
